raymarch_frame_scheduler: RTL and testbench
===========================================

# raymarch_frame_scheduler

Sequences one full 640x480 frame of pixel coordinates into the fully pipelined, non-stallable `raymarcher` datapath and collects its RGB results in order. Results are delivered to a valid/ready framebuffer write port. A credit scheme bounds in-flight pixels to the output FIFO depth, so back-pressure never drops a pixel. The block also owns the camera (look-at matrix and eye) registers: the HPS writes shadow copies, and the block commits them to the datapath only at a drained frame boundary.

## Interface
Parameters:
- `LATENCY`, 320: cycles from `pix_x`/`pix_y` change to matching `pix_red/green/blue`. Must equal the built raymarcher latency.
- `FIFO_DEPTH`, 512: result FIFO entries, power of two. Full rate requires `FIFO_DEPTH >= LATENCY+2`.

Ports:
- `clk`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to render a frame; ignored unless `busy`=0
- `continuous`  in  1  when 1, a new frame starts automatically after each frame
- `busy`  out  1  high in any state other than IDLE
- `frame_done`  out  1  one-cycle pulse after the last pixel's fb handshake
- `cam_we`  in  1  shadow camera register write strobe
- `cam_sel`  in  4  0..8 = look_at_1_1..look_at_3_3 (row-major), 9..11 = eye_x/y/z, 12..15 ignored
- `cam_wdata`  in  27  shadow write data (27-bit float)
- `cam_commit`  in  1  one-cycle request to copy shadow registers to live registers
- `look_at_1_1`..`look_at_3_3`  out  27 each  live matrix to raymarcher
- `eye_x`, `eye_y`, `eye_z`  out  27 each  live eye to raymarcher
- `pix_x`  out  10  pixel column to raymarcher
- `pix_y`  out  10  pixel row to raymarcher
- `pix_red`, `pix_green`, `pix_blue`  in  8 each  raymarcher color outputs
- `fb_valid`  out  1  write request
- `fb_ready`  in  1  framebuffer accepts when `fb_valid`&&`fb_ready`
- `fb_addr`  out  19  y*640+x
- `fb_data`  out  24  {red,green,blue}

## Operation
- States: IDLE, ISSUE, DRAIN, COMMIT.
  - IDLE → COMMIT if a commit is pending; else → ISSUE on `start`.
  - ISSUE → DRAIN the cycle after pixel (639,479) issues.
  - DRAIN → COMMIT when outstanding==0 and a commit is pending; else → ISSUE if `continuous`; else → IDLE.
  - COMMIT (one cycle) copies shadow to live and clears pending; then → ISSUE if `continuous` or `start` was latched, else → IDLE.
- Issue: raster order; x increments to 639, then wraps to 0 with y+1.
  - A pixel issues in a cycle only in ISSUE with outstanding < `FIFO_DEPTH`.
  - Outstanding = in-flight valid bits + FIFO count.
  - On an issue cycle, `pix_x`/`pix_y` register the new coordinate. Otherwise they hold their value, and a 0 enters the valid delay line.
- Valid delay line: a `LATENCY`-deep shift register. When its tap is 1, {`pix_red`,`pix_green`,`pix_blue`} is pushed into the FIFO that cycle. Overflow is impossible by construction; any overflow is an assertion failure.
- Output: `fb_valid` = FIFO non-empty.
  - `fb_addr` comes from a separate counter that increments on each handshake and wraps from 307199 to 0.
  - `fb_data`/`fb_addr` hold while `fb_valid`&&!`fb_ready`.
- Camera:
  - `cam_we` writes the shadow register at any time.
  - `cam_commit` sets pending in any state.
  - If `cam_we` and the COMMIT copy occur in the same cycle, the copy takes the pre-write shadow value.
  - Live registers never change during ISSUE or DRAIN.
- `start` during a busy state is latched only in DRAIN and COMMIT; otherwise it is ignored.

## Timing
- Reset (async assert, sync deassert):
  - State IDLE; `busy`=0, `frame_done`=0, `fb_valid`=0, `fb_addr`=0, `fb_data`=0, `pix_x`=`pix_y`=0.
  - FIFO empty, valid line cleared, pending=0.
  - Live and shadow look_at = identity (diagonal 27'h1fc0000 = 1.0, others 0).
  - Eye = (0, 0, 27'h2020000 = 3.0).
- Reset mid-frame aborts all in-flight pixels with no fb writes. The next frame restarts at address 0.
- `start` at cycle t: ISSUE at t+1, first pixel on `pix_x`/`pix_y` at t+2.
- Pixel issued (registered) at cycle u: its color is pushed at u+`LATENCY`, and `fb_valid` can assert at u+`LATENCY`+1.
- With `fb_ready`=1 and `FIFO_DEPTH>=LATENCY+2`: 1 pixel/cycle, frame ≈ 307200+`LATENCY`+4 cycles.
- `frame_done` is high the cycle after the handshake of address 307199.

## Test plan
- Reset, `start`, `fb_ready`=1, LATENCY=8, stub raymarcher returns color = {x[7:0], y[7:0], 8'h5A} delayed 8 cycles → 307200 writes, addr 0..307199 in order, data matches, one `frame_done`, `busy` falls.
- `fb_ready` random 30% duty, FIFO_DEPTH=16 → no lost or duplicated writes, data matches address, outstanding never exceeds 16.
- Write shadow look_at_1_1=27'h2000000 mid-ISSUE plus `cam_commit` → live stays 27'h1fc0000 until DRAIN empties, then changes in COMMIT.
- Same-cycle `cam_we`(sel 9, 27'h1fc0000) with the COMMIT copy → `eye_x` takes the old shadow value; the next commit yields 27'h1fc0000.
- `continuous`=1 for two frames → `frame_done` twice, `fb_addr` wraps 307199→0, no IDLE between frames.
- Assert `reset_n`=0 at pixel 1000 → `fb_valid`=0 immediately; after `start`, the first write is addr 0.

Source files
------------

// File: rtl/raymarch_frame_scheduler.sv
// raymarch_frame_scheduler: raster pixel issue into a fixed-latency raymarcher, in-order result FIFO, camera shadow/live registers
module raymarch_frame_scheduler #(
  parameter int LATENCY    = 320,
  parameter int FIFO_DEPTH = 512,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        continuous,
  output logic        busy,
  output logic        frame_done,
  input  logic        cam_we,
  input  logic [3:0]  cam_sel,
  input  logic [26:0] cam_wdata,
  input  logic        cam_commit,
  output logic [26:0] look_at_1_1,
  output logic [26:0] look_at_1_2,
  output logic [26:0] look_at_1_3,
  output logic [26:0] look_at_2_1,
  output logic [26:0] look_at_2_2,
  output logic [26:0] look_at_2_3,
  output logic [26:0] look_at_3_1,
  output logic [26:0] look_at_3_2,
  output logic [26:0] look_at_3_3,
  output logic [26:0] eye_x,
  output logic [26:0] eye_y,
  output logic [26:0] eye_z,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  input  logic [7:0]  pix_red,
  input  logic [7:0]  pix_green,
  input  logic [7:0]  pix_blue,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [18:0] fb_addr,
  output logic [23:0] fb_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [9:0] X_MAX = 10'(H_RES - 1);
  localparam logic [9:0] Y_MAX = 10'(V_RES - 1);
  localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;
  state_t state, state_n;

  logic [AW:0]        outst, wr_ptr, rd_ptr;
  logic [23:0]        mem [FIFO_DEPTH];
  logic [LATENCY-1:0] vline;
  logic               pix_v, issue, last_pix, push, hs, empty, full, drained, go;
  logic               start_lat, pending;
  logic [9:0]         nx, ny;
  logic [26:0]        shadow [12];
  logic [26:0]        live [12];

  function automatic logic [26:0] cam_init(input int i);
    return (i == 0 || i == 4 || i == 8) ? 27'h1fc0000 : (i == 11) ? 27'h2020000 : 27'h0;
  endfunction

  // Outstanding counts issued pixels not yet handshaken, so it covers both the delay line and the FIFO
  assign issue    = state == ISSUE && !outst[AW];
  assign last_pix = nx == X_MAX && ny == Y_MAX;
  assign push     = vline[LATENCY-1];
  assign empty    = wr_ptr == rd_ptr;
  assign full     = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign fb_valid = !empty;
  assign hs       = fb_valid && fb_ready;
  assign fb_data  = empty ? 24'h0 : mem[rd_ptr[AW-1:0]];
  assign drained  = outst == '0;
  assign go       = continuous || start_lat || start;

  assign look_at_1_1 = live[0];
  assign look_at_1_2 = live[1];
  assign look_at_1_3 = live[2];
  assign look_at_2_1 = live[3];
  assign look_at_2_2 = live[4];
  assign look_at_2_3 = live[5];
  assign look_at_3_1 = live[6];
  assign look_at_3_2 = live[7];
  assign look_at_3_3 = live[8];
  assign eye_x       = live[9];
  assign eye_y       = live[10];
  assign eye_z       = live[11];

  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;

  // Next state: a pending commit always waits for a fully drained pipeline
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pending ? COMMIT : start ? ISSUE : IDLE;
      ISSUE:   state_n = (issue && last_pix) ? DRAIN : ISSUE;
      DRAIN:   state_n = pending ? (drained ? COMMIT : DRAIN) : go ? ISSUE : drained ? IDLE : DRAIN;
      default: state_n = go ? ISSUE : IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb busy = state != IDLE;

  // Raster coordinate generator and registered pixel/valid toward the raymarcher
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {pix_x, pix_y, nx, ny, pix_v} <= '0;
      vline <= '0;
    end else begin
      pix_v <= issue;
      vline <= {vline[LATENCY-2:0], pix_v};
      if (issue) begin
        pix_x <= nx;
        pix_y <= ny;
        nx    <= nx == X_MAX ? 10'd0 : nx + 10'd1;
        ny    <= nx == X_MAX ? (ny == Y_MAX ? 10'd0 : ny + 10'd1) : ny;
      end
    end

  // Result FIFO storage, written when the delayed valid reaches the tap
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {pix_red, pix_green, pix_blue};

  // FIFO pointers, credit counter, framebuffer address and end-of-frame pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {wr_ptr, rd_ptr, outst} <= '0;
      fb_addr    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + (AW+1)'(push);
      rd_ptr     <= rd_ptr + (AW+1)'(hs);
      outst      <= outst + (AW+1)'(issue) - (AW+1)'(hs);
      fb_addr    <= hs ? (fb_addr == LAST_ADDR ? 19'd0 : fb_addr + 19'd1) : fb_addr;
      frame_done <= hs && fb_addr == LAST_ADDR;
    end

  // The credit bound makes a push into a full FIFO unreachable
  always_ff @(posedge clk)
    if (reset_n) assert (!(push && full)) else $error("result FIFO overflow");

  // Commit request and start request latches; a commit request arriving with the copy stays pending
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending   <= 1'b0;
      start_lat <= 1'b0;
    end else begin
      pending   <= cam_commit || (pending && state != COMMIT);
      start_lat <= (state_n == ISSUE || state_n == IDLE) ? 1'b0 : start_lat || (start && state != ISSUE);
    end

  // Shadow writes at any time; live copy only in COMMIT, which sees the pre-write shadow
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 12; i++) begin
        shadow[i] <= cam_init(i);
        live[i]   <= cam_init(i);
      end
    end else begin
      if (cam_we && cam_sel < 4'd12) shadow[cam_sel] <= cam_wdata;
      if (state == COMMIT) live <= shadow;
    end
endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// tb_raymarch_frame_scheduler: directed scoreboard bench on a reduced 16x8 frame with a stub raymarcher
module tb_raymarch_frame_scheduler;
  localparam int LAT = 8;
  localparam int DEPTH = 16;
  localparam int HR = 16;
  localparam int VR = 8;
  localparam int NPIX = HR * VR;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, continuous = 1'b0;
  logic        busy, frame_done, cam_we = 1'b0, cam_commit = 1'b0, fb_valid, fb_ready = 1'b1;
  logic [3:0]  cam_sel = '0;
  logic [26:0] cam_wdata = '0;
  logic [26:0] l11, l12, l13, l21, l22, l23, l31, l32, l33, ex, ey, ez;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_red, pix_green, pix_blue;
  logic [18:0] fb_addr;
  logic [23:0] fb_data;

  int compared = 0, mismatched = 0, wr_cnt = 0, idle_seen = 0;
  bit rnd_ready = 0;
  logic [42:0] sb[$];
  logic [23:0] pipe [LAT];

  raymarch_frame_scheduler #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .H_RES(HR), .V_RES(VR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous), .busy(busy),
    .frame_done(frame_done), .cam_we(cam_we), .cam_sel(cam_sel), .cam_wdata(cam_wdata),
    .cam_commit(cam_commit), .look_at_1_1(l11), .look_at_1_2(l12), .look_at_1_3(l13),
    .look_at_2_1(l21), .look_at_2_2(l22), .look_at_2_3(l23), .look_at_3_1(l31),
    .look_at_3_2(l32), .look_at_3_3(l33), .eye_x(ex), .eye_y(ey), .eye_z(ez),
    .pix_x(pix_x), .pix_y(pix_y), .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= {pix_x[7:0], pix_y[7:0], 8'h5A};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign {pix_red, pix_green, pix_blue} = pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n && fb_valid && fb_ready) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL spurious_write observed addr=%0d expected no write", fb_addr);
      end else begin
        logic [42:0] e;
        e = sb.pop_front();
        chk("fb_addr", fb_addr, e[42:24]);
        chk("fb_data", fb_data, e[23:0]);
      end
    end

  task automatic push_frame();
    for (int a = 0; a < NPIX; a++)
      sb.push_back({19'(a), 8'(a % HR), 8'(a / HR), 8'h5A});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    fb_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      step();
      n++;
      if (!busy) idle_seen = 1;
    end while (!frame_done && n < 3000);
    chk(tag, frame_done, 1'b1);
  endtask

  initial begin
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_fb_valid", fb_valid, 1'b0);
    chk("rst_fb_addr", fb_addr, 19'd0);
    chk("rst_fb_data", fb_data, 24'd0);
    chk("rst_pix", {pix_x, pix_y}, 20'd0);
    chk("rst_l11", l11, 27'h1fc0000);
    chk("rst_l12", l12, 27'h0);
    chk("rst_l33", l33, 27'h1fc0000);
    chk("rst_eye_x", ex, 27'h0);
    chk("rst_eye_z", ez, 27'h2020000);
    reset_n = 1'b1;
    step();

    push_frame();
    pulse_start();
    chk("start_busy", busy, 1'b1);
    step();
    step();
    chk("second_pixel", {pix_x, pix_y}, {10'd1, 10'd0});
    wait_done("frame1_done");
    chk("frame1_all_written", sb.size(), 0);
    step();
    step();
    chk("frame1_busy_falls", busy, 1'b0);

    rnd_ready = 1;
    push_frame();
    pulse_start();
    wait_done("rand_done");
    chk("rand_all_written", sb.size(), 0);
    rnd_ready = 0;
    for (int i = 0; i < 4; i++) step();

    push_frame();
    pulse_start();
    for (int i = 0; i < 10; i++) step();
    cam_we = 1'b1; cam_sel = 4'd0; cam_wdata = 27'h2000000; cam_commit = 1'b1;
    step();
    cam_we = 1'b0; cam_commit = 1'b0;
    chk("cam_issue_hold", l11, 27'h1fc0000);
    wait_done("cam_frame_done");
    chk("cam_drain_hold", l11, 27'h1fc0000);
    chk("cam_drain_busy", busy, 1'b1);
    step();
    chk("cam_commit_cycle_hold", l11, 27'h1fc0000);
    step();
    chk("cam_committed", l11, 27'h2000000);
    chk("cam_idle_after", busy, 1'b0);

    cam_we = 1'b1; cam_sel = 4'd9; cam_wdata = 27'h0400000;
    step();
    cam_we = 1'b0;
    cam_commit = 1'b1;
    step();
    cam_commit = 1'b0;
    step();
    cam_we = 1'b1; cam_sel = 4'd9; cam_wdata = 27'h1fc0000;
    chk("same_cycle_in_commit", busy, 1'b1);
    step();
    cam_we = 1'b0;
    chk("same_cycle_old_shadow", ex, 27'h0400000);
    cam_commit = 1'b1;
    step();
    cam_commit = 1'b0;
    step();
    step();
    chk("second_commit_new", ex, 27'h1fc0000);
    chk("l11_kept", l11, 27'h2000000);

    push_frame();
    push_frame();
    continuous = 1'b1;
    pulse_start();
    idle_seen = 0;
    wait_done("cont_done1");
    continuous = 1'b0;
    wait_done("cont_done2");
    chk("cont_no_idle", idle_seen, 0);
    chk("cont_all_written", sb.size(), 0);
    step();
    step();
    chk("cont_busy_falls", busy, 1'b0);

    begin
      int base = wr_cnt, n = 0;
      push_frame();
      pulse_start();
      while (wr_cnt < base + 50 && n < 2000) begin step(); n++; end
      chk("reset_reached_pixel", wr_cnt >= base + 50, 1'b1);
    end
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_fb_valid", fb_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    push_frame();
    pulse_start();
    wait_done("after_reset_done");
    chk("after_reset_all_written", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
